spi_ss_decoder: RTL and testbench

- Registered binary (NKB) to one-hot slave-select decoder for the SPI execution unit. This is the inverse path of the one-hot-to-NKB encoder.
- Takes a binary slave index plus a request. Drives one active-low SS line with programmable setup and hold delays around the transfer.
- Sits between the SPI master control FSM and the SS pins. The control FSM waits on o_ready before starting SCLK.

---
 rtl/spi_ss_decoder.sv | 147 ++++++++++++++
 tb/tb_spi_ss_decoder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ss_decoder.sv
// Registered binary-index to one-hot active-low slave-select decoder with
// programmable setup/hold timing. Optional SS-high gap state: SPI_SS_IDLE_GAP_EN.
module spi_ss_decoder #(
    parameter  int SLAVES    = 4,
    parameter  int SETUP_CYC = 2,
    parameter  int HOLD_CYC  = 2,
    parameter  int GAP_CYC   = 3,
    localparam int BITS      = $clog2(SLAVES)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic [BITS-1:0]   i_nkb,
    input  logic              i_release,
    output logic [SLAVES-1:0] o_ss_n,
    output logic              o_ready,
    output logic              o_busy,
    output logic              o_err
);

    if (SLAVES < 2 || SLAVES > 32 || SETUP_CYC < 1 || SETUP_CYC > 255 ||
        HOLD_CYC < 1 || HOLD_CYC > 255 || GAP_CYC < 1 || GAP_CYC > 255) begin : g_bad_param
        $error("spi_ss_decoder: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACTIVE,
        S_HOLD
`ifdef SPI_SS_IDLE_GAP_EN
        , S_GAP
`endif
    } state_t;

    localparam logic [SLAVES-1:0] SS_ONE  = SLAVES'(1);
    localparam logic [SLAVES-1:0] SS_NONE = '1;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [SLAVES-1:0] ss_n_q, ss_n_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [31:0]       nkb_ext;
    logic              in_range;

    // Non-power-of-two SLAVES leaves encodable indices with no SS line.
    assign nkb_ext  = {{(32-BITS){1'b0}}, i_nkb};
    assign in_range = (nkb_ext < 32'(SLAVES));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ss_n_q  <= SS_NONE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ss_n_q  <= ss_n_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ss_n_d  = ss_n_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                ss_n_d  = SS_NONE;
                ready_d = 1'b0;
                busy_d  = 1'b0;
                if (i_req) begin
                    if (in_range) begin
                        ss_n_d  = ~(SS_ONE << i_nkb);
                        busy_d  = 1'b1;
                        state_d = S_SETUP;
                        cnt_d   = 8'(SETUP_CYC - 1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_ACTIVE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_ACTIVE: begin
                if (i_release) begin
                    ready_d = 1'b0;
                    state_d = S_HOLD;
                    cnt_d   = 8'(HOLD_CYC - 1);
                end
            end
            S_HOLD: begin
                if (cnt_q == 8'd0) begin
                    ss_n_d = SS_NONE;
`ifdef SPI_SS_IDLE_GAP_EN
                    state_d = S_GAP;
                    cnt_d   = 8'(GAP_CYC - 1);
`else
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
`ifdef SPI_SS_IDLE_GAP_EN
            S_GAP: begin
                // Busy stays high so the master cannot launch into the gap.
                if (cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                ss_n_d  = SS_NONE;
                ready_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign o_ss_n  = ss_n_q;
    assign o_ready = ready_q;
    assign o_busy  = busy_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_spi_ss_decoder.sv
// Bench for spi_ss_decoder: a timeline model (accept/release edge numbers)
// checked every cycle on a 4-slave and a 5-slave instance, plus literal checks.
module tb_spi_ss_decoder;

    localparam int SETUP = 2;
    localparam int HOLD  = 2;
    localparam int GAP   = 3;
`ifdef SPI_SS_IDLE_GAP_EN
    localparam int GAPX  = GAP;
`else
    localparam int GAPX  = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, req_a, rel_a, req_b, rel_b;
    logic [1:0] nkb_a;
    logic [2:0] nkb_b;
    logic [3:0] ss_a;
    logic [4:0] ss_b;
    logic       ready_a, busy_a, err_a, ready_b, busy_b, err_b;

    spi_ss_decoder #(.SLAVES(4), .SETUP_CYC(SETUP), .HOLD_CYC(HOLD), .GAP_CYC(GAP)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_req(req_a), .i_nkb(nkb_a), .i_release(rel_a),
        .o_ss_n(ss_a), .o_ready(ready_a), .o_busy(busy_a), .o_err(err_a));

    spi_ss_decoder #(.SLAVES(5), .SETUP_CYC(SETUP), .HOLD_CYC(HOLD), .GAP_CYC(GAP)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_req(req_b), .i_nkb(nkb_b), .i_release(rel_b),
        .o_ss_n(ss_b), .o_ready(ready_b), .o_busy(busy_b), .o_err(err_b));

    int checks   = 0;
    int failures = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Timeline model: each instance remembers its accept edge k, release edge m,
    // the edge from which it is idle again, and the last rejected-request edge.
    int  n = 0;
    bit  started = 0;
    bit  act_m[2];
    int  k_m[2], m_m[2], idle_at[2], idx_m[2], err_at[2];

    always @(posedge clk) begin
        n++;
        if (rst) started = 1;
        for (int i = 0; i < 2; i++) begin
            bit rq, rl;
            int nk, sl;
            rq = (i == 1) ? req_b : req_a;
            rl = (i == 1) ? rel_b : rel_a;
            nk = (i == 1) ? int'(nkb_b) : int'(nkb_a);
            sl = (i == 1) ? 5 : 4;
            if (rst) begin
                act_m[i] = 0; idle_at[i] = n; err_at[i] = -1; m_m[i] = -1;
            end else begin
                if (act_m[i] && m_m[i] != -1 && n - 1 >= idle_at[i]) act_m[i] = 0;
                if (!act_m[i]) begin
                    if (idle_at[i] <= n - 1 && rq) begin
                        if (nk < sl) begin
                            act_m[i] = 1; k_m[i] = n; m_m[i] = -1; idx_m[i] = nk;
                        end else begin
                            err_at[i] = n;
                        end
                    end
                end else if (m_m[i] == -1 && n - 1 >= k_m[i] + SETUP && rl) begin
                    m_m[i] = n;
                    idle_at[i] = n + HOLD + GAPX;
                end
            end
        end
    end

    function automatic logic [31:0] exp_ss(int i);
        if (act_m[i] && n >= k_m[i] && (m_m[i] == -1 || n < m_m[i] + HOLD))
            return ~(32'd1 << idx_m[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] exp_busy(int i);
        return {31'd0, act_m[i] && (m_m[i] == -1 || n < idle_at[i])};
    endfunction

    function automatic logic [31:0] exp_ready(int i);
        return {31'd0, act_m[i] && n >= k_m[i] + SETUP && (m_m[i] == -1 || n < m_m[i])};
    endfunction

    always @(negedge clk) begin
        if (started) begin
            cmp("a_ss",    32'(ss_a),    exp_ss(0) & 32'hF);
            cmp("a_ready", 32'(ready_a), exp_ready(0));
            cmp("a_busy",  32'(busy_a),  exp_busy(0));
            cmp("a_err",   32'(err_a),   {31'd0, err_at[0] == n});
            cmp("b_ss",    32'(ss_b),    exp_ss(1) & 32'h1F);
            cmp("b_ready", 32'(ready_b), exp_ready(1));
            cmp("b_busy",  32'(busy_b),  exp_busy(1));
            cmp("b_err",   32'(err_b),   {31'd0, err_at[1] == n});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int gap;

    initial begin
        rst = 1; req_a = 0; rel_a = 0; nkb_a = 0; req_b = 0; rel_b = 0; nkb_b = 0;
        repeat (2) step();
        rst = 0;
        cmp("rst_ss",    32'(ss_a), 32'hF);
        cmp("rst_ready", 32'(ready_a), 0);
        cmp("rst_busy",  32'(busy_a), 0);
        cmp("rst_err",   32'(err_a), 0);
        step();

        // Test 1/2: index 2, setup then release and hold.
        req_a = 1; nkb_a = 2;
        step();
        req_a = 0;
        cmp("t1_ss_k",     32'(ss_a), 32'b1011);
        cmp("t1_busy_k",   32'(busy_a), 1);
        cmp("t1_ready_k",  32'(ready_a), 0);
        step();
        cmp("t1_ready_k1", 32'(ready_a), 0);
        step();
        cmp("t1_ready_k2", 32'(ready_a), 1);
        repeat (7) step();
        rel_a = 1;
        step();
        rel_a = 0;
        cmp("t2_ready_m",  32'(ready_a), 0);
        cmp("t2_ss_m",     32'(ss_a), 32'b1011);
        step();
        cmp("t2_ss_m1",    32'(ss_a), 32'b1011);
        cmp("t2_busy_m1",  32'(busy_a), 1);
        step();
        cmp("t2_ss_m2",    32'(ss_a), 32'hF);
        cmp("t2_busy_m2",  32'(busy_a), (GAPX > 0) ? 1 : 0);
        repeat (GAPX + 1) step();

        // Test 3: out-of-range index on the 5-slave instance, then index 4.
        req_b = 1; nkb_b = 6;
        step();
        cmp("t3_err",      32'(err_b), 1);
        cmp("t3_ss",       32'(ss_b), 32'h1F);
        cmp("t3_busy",     32'(busy_b), 0);
        nkb_b = 4;
        step();
        req_b = 0;
        cmp("t3_err_once", 32'(err_b), 0);
        cmp("t3_ss4",      32'(ss_b), 32'b01111);
        repeat (3) step();
        rel_b = 1;
        step();
        rel_b = 0;
        repeat (HOLD + GAPX + 1) step();

        // Test 4: reset while ACTIVE drops SS with no hold.
        req_a = 1; nkb_a = 1;
        step();
        req_a = 0;
        repeat (2) step();
        cmp("t4_ready",    32'(ready_a), 1);
        cmp("t4_ss",       32'(ss_a), 32'b1101);
        step();
        rst = 1;
        step();
        rst = 0;
        cmp("t4_ss_rst",   32'(ss_a), 32'hF);
        cmp("t4_ready_rst", 32'(ready_a), 0);
        cmp("t4_busy_rst", 32'(busy_a), 0);
        step();
        cmp("t4_ss_after", 32'(ss_a), 32'hF);

        // Test 5: request held high, measure SS-high gap between selects.
        req_a = 1; nkb_a = 3;
        step();
        for (int it = 0; it < 3; it++) begin
            for (int w = 0; w < 20 && ready_a !== 1'b1; w++) step();
            cmp("t5_ready", 32'(ready_a), 1);
            rel_a = 1;
            step();
            rel_a = 0;
            for (int w = 0; w < 20 && ss_a !== 4'hF; w++) step();
            cmp("t5_ss_high", 32'(ss_a), 32'hF);
            gap = 0;
            while (ss_a === 4'hF && gap < 20) begin
                gap++;
                step();
            end
            cmp("t5_gap", gap, 1 + GAPX);
            cmp("t5_ss_again", 32'(ss_a), 32'b0111);
        end
        req_a = 0;
        for (int w = 0; w < 20 && ready_a !== 1'b1; w++) step();
        rel_a = 1;
        step();
        rel_a = 0;
        repeat (HOLD + GAPX + 2) step();

        // Test 6: index churn and early release must not disturb the transfer.
        req_a = 1; nkb_a = 0;
        step();
        req_a = 0; rel_a = 1; nkb_a = 2'd3;
        step();
        cmp("t6_ss_k1",    32'(ss_a), 32'b1110);
        cmp("t6_ready_k1", 32'(ready_a), 0);
        nkb_a = 2'd1;
        step();
        rel_a = 0;
        cmp("t6_ready_k2", 32'(ready_a), 1);
        for (int j = 0; j < 5; j++) begin
            nkb_a = nkb_a + 2'd1;
            step();
            cmp("t6_ss_act", 32'(ss_a), 32'b1110);
        end
        rel_a = 1; nkb_a = nkb_a + 2'd1;
        step();
        rel_a = 0; nkb_a = nkb_a + 2'd1;
        step();
        cmp("t6_ss_hold",  32'(ss_a), 32'b1110);
        step();
        cmp("t6_ss_end",   32'(ss_a), 32'hF);
        repeat (GAPX + 2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
